// File: rtl/mix_col_seq_pkg.sv
// Shared definitions for the column-serial AES MixColumns block: FSM encoding,
// column counter width and GF(2^8) helpers over the 0x11B polynomial.
package mix_col_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         CNT_W = 2;
  localparam logic [8:0] POLY  = 9'h11B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [8:0] s;
    s = {b, 1'b0};
    if (s[8]) s = s ^ POLY;
    return s[7:0];
  endfunction

  // Multiplies by a small constant; four bits cover every MixColumns coefficient.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

endpackage

// File: rtl/mix_col32.sv
// Combinational single-column (Inv)MixColumns; byte 0 is the MSB.
// MIX_COL_INV_EN enables the inverse matrix, otherwise inv is ignored.
module mix_col32 (
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] res
);
  import mix_col_seq_pkg::*;

  // First matrix row; row r uses this row rotated right by r.
  logic [3:0] coef [4];

  always_comb begin
`ifdef MIX_COL_INV_EN
    if (inv) begin
      coef[0] = 4'he;
      coef[1] = 4'hb;
      coef[2] = 4'hd;
      coef[3] = 4'h9;
    end else begin
      coef[0] = 4'h2;
      coef[1] = 4'h3;
      coef[2] = 4'h1;
      coef[3] = 4'h1;
    end
`else
    coef[0] = 4'h2;
    coef[1] = 4'h3;
    coef[2] = 4'h1;
    coef[3] = 4'h1;
`endif
  end

`ifndef MIX_COL_INV_EN
  logic unused_inv;
  assign unused_inv = inv;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      logic [7:0] acc;
      always_comb begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(col[31-8*j -: 8], coef[2'(j - gi)]);
        end
      end
      assign res[31-8*gi -: 8] = acc;
    end
  endgenerate

endmodule

// File: rtl/mix_col_seq.sv
// Column-serial AES MixColumns: accepts a 128-bit state, mixes one column per
// cycle through a single mix_col32, then holds the result until consumed.
// MIX_COL_INV_EN enables in_inv (InvMixColumns); otherwise in_inv is ignored.
module mix_col_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  import mix_col_seq_pkg::*;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [127:0]       data_reg, data_next;
  logic               inv_reg, inv_next;
  logic [6:0]         col_base;
  logic [31:0]        col_in;
  logic [31:0]        col_out;

  // Column c sits at bit offset (3-c)*32, i.e. {~c, 5'b0}.
  assign col_base = {~cnt_reg, 5'b0};
  assign col_in   = data_reg[col_base +: 32];

  mix_col32 u_mix (
    .col (col_in),
    .inv (inv_reg),
    .res (col_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      data_reg  <= '0;
      inv_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      inv_reg   <= inv_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    inv_next   = inv_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_next  = in_data;
          inv_next   = in_inv;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        data_next[col_base +: 32] = col_out;
        if (cnt_reg == {CNT_W{1'b1}}) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_data = data_reg;

endmodule

// File: tb/tb_mix_col_seq.sv
// Directed self-checking bench for mix_col_seq using hand-computed AES vectors.
// Expected inverse-vector result follows MIX_COL_INV_EN.
module tb_mix_col_seq;

  localparam logic [127:0] V_FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V_SEQ_IN  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] V_SEQ_OUT = 128'h02070005_06030401_0a0f080d_0e0b0c09;
  // Forward MixColumns applied to V_FWD_OUT
  localparam logic [127:0] V_REFWD   = 128'hcd504506_9f494f1f_01010101_c6c6c6c6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  mix_col_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one state and keep in_valid for exactly the accepting edge,
  // then scramble the inputs so late changes would corrupt a faulty design.
  task automatic accept(input logic [127:0] data, input logic inv);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    chk("in_ready_wait", 128'(in_ready), 128'(1));
    in_data  = data;
    in_inv   = inv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = ~data;
    in_inv   = ~inv;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [127:0] data, input logic inv,
                         input logic [127:0] exp);
    int lat;
    out_ready = 1'b0;
    accept(data, inv);
    wait_done(lat);
    chk({tag, "_latency"}, 128'(lat), 128'(4));
    chk({tag, "_data"}, out_data, exp);
    $display("vec %s in=%h inv=%0d out=%h latency=%0d", tag, data, inv, out_data, lat);
    out_ready = 1'b1;
    step();
    chk({tag, "_idle_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_idle_valid"}, 128'(out_valid), 128'(0));
    out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] held;
    logic [127:0] vecs [3];
    logic [127:0] exps [3];
    logic [127:0] exp_q [$];
    int           acc_q [$];
    int           cyc;
    int           nacc;
    int           nres;
    int           pulses;
    int           lat;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_data", out_data, '0);
    rst = 1'b0;
    step();

    run_vec("fwd", V_FWD_IN, 1'b0, V_FWD_OUT);
    run_vec("seq", V_SEQ_IN, 1'b0, V_SEQ_OUT);
`ifdef MIX_COL_INV_EN
    run_vec("inv", V_FWD_OUT, 1'b1, V_FWD_IN);
`else
    run_vec("inv", V_FWD_OUT, 1'b1, V_REFWD);
`endif

    // Back-pressure: result held for 10 cycles while new requests are offered.
    accept(V_SEQ_IN, 1'b0);
    wait_done(lat);
    chk("bp_latency", 128'(lat), 128'(4));
    held     = out_data;
    chk("bp_data", held, V_SEQ_OUT);
    in_valid = 1'b1;
    in_data  = V_FWD_IN;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_stable", out_data, V_SEQ_OUT);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_out_valid", 128'(out_valid), 128'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_ready", 128'(in_ready), 128'(1));
    chk("bp_release_valid", 128'(out_valid), 128'(0));
    chk("bp_ignored_input", out_data, V_SEQ_OUT);
    $display("backpressure held=%h after_release=%h", held, out_data);
    out_ready = 1'b0;

    // Reset while in RUN with col_cnt=2, alongside competing handshakes.
    accept(V_FWD_IN, 1'b0);
    step();
    step();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_run_in_ready", 128'(in_ready), 128'(1));
    chk("rst_run_out_valid", 128'(out_valid), 128'(0));
    chk("rst_run_out_data", out_data, '0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) pulses++;
    end
    chk("rst_no_pulse", 128'(pulses), 128'(0));
    $display("reset_in_run out_data=%h pulses=%0d", out_data, pulses);
    run_vec("after_rst", V_FWD_IN, 1'b0, V_FWD_OUT);

    // Back-to-back with in_valid and out_ready held high.
    vecs[0] = V_FWD_IN;  exps[0] = V_FWD_OUT;
    vecs[1] = V_SEQ_IN;  exps[1] = V_SEQ_OUT;
    vecs[2] = V_FWD_OUT; exps[2] = V_REFWD;
    cyc       = 0;
    nacc      = 0;
    nres      = 0;
    in_inv    = 1'b0;
    in_data   = vecs[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (nres < 3 && cyc < 80) begin
      if (in_ready && in_valid) begin
        exp_q.push_back(exps[nacc]);
        acc_q.push_back(cyc + 1);
        nacc++;
      end
      step();
      cyc++;
      if (nacc < 3) in_data = vecs[nacc];
      else          in_valid = 1'b0;
      if (in_ready && out_valid) chk("b2b_exclusive", 128'(1), 128'(0));
      if (out_valid) begin
        chk("b2b_data", out_data, exp_q.pop_front());
        chk("b2b_latency", 128'(cyc - acc_q.pop_front()), 128'(4));
        $display("b2b result %0d out=%h cycle=%0d", nres, out_data, cyc);
        nres++;
      end
    end
    chk("b2b_count", 128'(nres), 128'(3));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
